// File: rtl/jk_flipflop_bank.sv
// Bank of WIDTH run-time configurable flip-flops (JK / T / D / SR / COUNT).
// Each bit is a per-lane cell; the top module builds the T-chain and registers the flags.

module jk_flipflop_cell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [2:0] mode,
  input  logic       a,
  input  logic       b,
  input  logic       t_chain,
  output logic       q,
  output logic       sr_bad
);
  localparam logic [2:0] MODE_JK    = 3'b000;
  localparam logic [2:0] MODE_T     = 3'b001;
  localparam logic [2:0] MODE_D     = 3'b010;
  localparam logic [2:0] MODE_SR    = 3'b011;
  localparam logic [2:0] MODE_COUNT = 3'b100;

  logic q_nxt;

  always_comb begin
    q_nxt = q;
    case (mode)
      MODE_JK: begin
        case ({a, b})
          2'b01:   q_nxt = 1'b0;
          2'b10:   q_nxt = 1'b1;
          2'b11:   q_nxt = ~q;
          default: q_nxt = q;
        endcase
      end
      MODE_T:     q_nxt = a ? ~q : q;
      MODE_D:     q_nxt = a;
      MODE_SR: begin
        // S=R=1 is illegal: hold this bit, neighbours still update
        case ({a, b})
          2'b01:   q_nxt = 1'b0;
          2'b10:   q_nxt = 1'b1;
          default: q_nxt = q;
        endcase
      end
      MODE_COUNT: q_nxt = t_chain ? ~q : q;
      default:    q_nxt = q;
    endcase
  end

  assign sr_bad = en && (mode == MODE_SR) && a && b;

  always_ff @(posedge clk) begin
    if (reset)   q <= RST_BIT;
    else if (en) q <= q_nxt;
  end
endmodule

module jk_flipflop_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             sr_err,
  output logic             mode_err,
  output logic             carry
);
  localparam logic [2:0] MODE_COUNT = 3'b100;

  typedef struct packed {
    logic sr_err;
    logic mode_err;
    logic carry;
  } flags_t;

  // chain[i] = bits 0..i-1 all ones; chain[WIDTH] marks the wrap point
  logic [WIDTH:0]   chain;
  logic [WIDTH-1:0] sr_bad;
  flags_t           flags, flags_nxt;

  assign chain[0] = 1'b1;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_lane
      assign chain[i+1] = chain[i] & q[i];
      jk_flipflop_cell #(.RST_BIT(RESET_VAL[i])) u_cell (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .mode    (mode),
        .a       (a[i]),
        .b       (b[i]),
        .t_chain (chain[i]),
        .q       (q[i]),
        .sr_bad  (sr_bad[i])
      );
    end
  endgenerate

  always_comb begin
    flags_nxt          = '0;
    flags_nxt.sr_err   = |sr_bad;
    flags_nxt.mode_err = en && mode[2] && (mode[1:0] != 2'b00);
    flags_nxt.carry    = en && (mode == MODE_COUNT) && chain[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) flags <= '0;
    else       flags <= flags_nxt;
  end

  assign qn       = ~q;
  assign sr_err   = flags.sr_err;
  assign mode_err = flags.mode_err;
  assign carry    = flags.carry;
endmodule
